// File: rtl/display_pkg.sv
// Shared constants and types for the multiplexed four-digit seven-segment driver.
package display_pkg;

  localparam int unsigned SEG_W            = 7;
  localparam int unsigned DIGITS           = 4;
  localparam int unsigned NIB_W            = 4;
  localparam int unsigned IDX_W            = 2;
  localparam int unsigned SCAN_DIV_DEFAULT = 50000;

  // Segment order {g,f,e,d,c,b,a}, active-high lit
  localparam logic [SEG_W-1:0] GLYPH_0   = 7'h3F;
  localparam logic [SEG_W-1:0] GLYPH_1   = 7'h06;
  localparam logic [SEG_W-1:0] GLYPH_2   = 7'h5B;
  localparam logic [SEG_W-1:0] GLYPH_3   = 7'h4F;
  localparam logic [SEG_W-1:0] GLYPH_4   = 7'h66;
  localparam logic [SEG_W-1:0] GLYPH_5   = 7'h6D;
  localparam logic [SEG_W-1:0] GLYPH_6   = 7'h7D;
  localparam logic [SEG_W-1:0] GLYPH_7   = 7'h07;
  localparam logic [SEG_W-1:0] GLYPH_8   = 7'h7F;
  localparam logic [SEG_W-1:0] GLYPH_9   = 7'h6F;
  localparam logic [SEG_W-1:0] GLYPH_A   = 7'h77;
  localparam logic [SEG_W-1:0] GLYPH_B   = 7'h7C;
  localparam logic [SEG_W-1:0] GLYPH_C   = 7'h39;
  localparam logic [SEG_W-1:0] GLYPH_D   = 7'h5E;
  localparam logic [SEG_W-1:0] GLYPH_E   = 7'h79;
  localparam logic [SEG_W-1:0] GLYPH_F   = 7'h71;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  localparam logic [DIGITS-1:0] AN_OFF = 4'b1111;

  // Coherent four-digit snapshot; d3 is most significant
  typedef struct packed {
    logic [NIB_W-1:0] d3;
    logic [NIB_W-1:0] d2;
    logic [NIB_W-1:0] d1;
    logic [NIB_W-1:0] d0;
  } digits_t;

  // Active-low one-hot anode enable for a digit index
  function automatic logic [DIGITS-1:0] an_select(input logic [IDX_W-1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to seven-segment glyph decoder.
module seg7_hex_decoder
  import display_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] glyph_c
);

  always_comb begin
    glyph_c = SEG_BLANK;
    unique case (nibble)
      4'h0: glyph_c = GLYPH_0;
      4'h1: glyph_c = GLYPH_1;
      4'h2: glyph_c = GLYPH_2;
      4'h3: glyph_c = GLYPH_3;
      4'h4: glyph_c = GLYPH_4;
      4'h5: glyph_c = GLYPH_5;
      4'h6: glyph_c = GLYPH_6;
      4'h7: glyph_c = GLYPH_7;
      4'h8: glyph_c = GLYPH_8;
      4'h9: glyph_c = GLYPH_9;
      4'hA: glyph_c = GLYPH_A;
      4'hB: glyph_c = GLYPH_B;
      4'hC: glyph_c = GLYPH_C;
      4'hD: glyph_c = GLYPH_D;
      4'hE: glyph_c = GLYPH_E;
      4'hF: glyph_c = GLYPH_F;
      default: glyph_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_4digit.sv
// Four-digit multiplexed seven-segment driver with per-frame snapshot and
// optional leading-zero blanking, driving a common-anode panel.
module display_scan_4digit
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NIB_W-1:0] in0,
  input  logic [NIB_W-1:0] in1,
  input  logic [NIB_W-1:0] in2,
  input  logic [NIB_W-1:0] in3,
  output logic [SEG_W-1:0] seg,
  output logic [DIGITS-1:0] an
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              load_flag_q, load_flag_d;
  digits_t           snap_q, snap_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;

  logic              tick_c;
  logic              frame_load_c;
  logic [NIB_W-1:0]  nibble_c;
  logic [DIGITS-1:0] lz_blank_c;
  logic              blank_c;
  logic [SEG_W-1:0]  glyph_c;

  seg7_hex_decoder u_dec (
    .nibble  (nibble_c),
    .glyph_c (glyph_c)
  );

  // Scan timing, snapshot load and output selection
  always_comb begin
    tick_c       = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
    frame_load_c = load_flag_q || (tick_c && (idx_q == 2'd3));

    div_cnt_d   = tick_c ? '0 : div_cnt_q + DIV_W'(1);
    idx_d       = tick_c ? idx_q + 2'd1 : idx_q;
    load_flag_d = 1'b0;
    snap_d      = frame_load_c ? digits_t'({in3, in2, in1, in0}) : snap_q;

    nibble_c = snap_q.d0;
    unique case (idx_q)
      2'd0: nibble_c = snap_q.d0;
      2'd1: nibble_c = snap_q.d1;
      2'd2: nibble_c = snap_q.d2;
      2'd3: nibble_c = snap_q.d3;
      default: nibble_c = snap_q.d0;
    endcase

    // A digit blanks only when it and every more significant digit are zero
    lz_blank_c[0] = 1'b0;
    lz_blank_c[1] = ({snap_q.d3, snap_q.d2, snap_q.d1} == 12'h000);
    lz_blank_c[2] = ({snap_q.d3, snap_q.d2} == 8'h00);
    lz_blank_c[3] = (snap_q.d3 == 4'h0);
    blank_c       = BLANK_LZ && lz_blank_c[idx_q];

    seg_d = blank_c ? SEG_BLANK : glyph_c;
    an_d  = an_select(idx_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q   <= '0;
      idx_q       <= '0;
      load_flag_q <= 1'b1;
      snap_q      <= '0;
      seg_q       <= SEG_BLANK;
      an_q        <= AN_OFF;
    end else begin
      div_cnt_q   <= div_cnt_d;
      idx_q       <= idx_d;
      load_flag_q <= load_flag_d;
      snap_q      <= snap_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_display_scan_4digit.sv
// Randomized self-checking bench for display_scan_4digit, one instance per
// blanking mode, compared every cycle against a frame-level behavioural model.
module tb_display_scan_4digit;

  localparam int unsigned SD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] in0 = 4'h0, in1 = 4'h0, in2 = 4'h0, in3 = 4'h0;
  logic [6:0] seg_nb, seg_lz;
  logic [3:0] an_nb, an_lz;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int unsigned edge_cnt;
  logic [15:0] m_snap;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg_nb, exp_seg_lz;

  display_scan_4digit #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .seg(seg_nb), .an(an_nb)
  );

  display_scan_4digit #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut_lz (
    .clk(clk), .reset(reset), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .seg(seg_lz), .an(an_lz)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Digit shown by the outputs after the t-th clock edge since reset release
  function automatic int unsigned digit_of(input int unsigned t);
    return ((t - 1) / SD) % 4;
  endfunction

  function automatic logic [6:0] exp_glyph(input logic [15:0] v, input int unsigned k,
                                           input bit blz);
    logic [15:0] upper;
    logic [15:0] nib;
    upper = v >> (4 * k);
    nib   = upper & 16'h000F;
    if (blz && k != 0 && upper == 16'h0000) return 7'h00;
    return hex_glyph(nib[3:0]);
  endfunction

  // Model: snapshot on first edge after release and at every frame boundary
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_cnt   <= 0;
      m_snap     <= 16'h0000;
      exp_an     <= 4'hF;
      exp_seg_nb <= 7'h00;
      exp_seg_lz <= 7'h00;
    end else begin
      exp_an     <= 4'hF ^ (4'b0001 << digit_of(edge_cnt + 1));
      exp_seg_nb <= exp_glyph(m_snap, digit_of(edge_cnt + 1), 1'b0);
      exp_seg_lz <= exp_glyph(m_snap, digit_of(edge_cnt + 1), 1'b1);
      if (edge_cnt == 0 || ((edge_cnt + 1) % (4 * SD)) == 0)
        m_snap <= {in3, in2, in1, in0};
      edge_cnt <= edge_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t edge=%0d: got %h expected %h", name, $time, edge_cnt, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("an_nb", 16'(an_nb), 16'(exp_an));
    chk("an_lz", 16'(an_lz), 16'(exp_an));
    chk("seg_nb", 16'(seg_nb), 16'(exp_seg_nb));
    chk("seg_lz", 16'(seg_lz), 16'(exp_seg_lz));
    if (!reset && edge_cnt > 0) begin
      chk("onehot_nb", 16'($countones(~an_nb)), 16'd1);
      chk("onehot_lz", 16'($countones(~an_lz)), 16'd1);
    end
  end

  task automatic set_in(input logic [15:0] v);
    {in3, in2, in1, in0} = v;
  endtask

  task automatic wait_edge(input int unsigned n);
    int unsigned guard = 0;
    @(negedge clk);
    while (edge_cnt < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (edge_cnt != n) chk("wait_edge", 16'(edge_cnt), 16'(n));
  endtask

  task automatic restart(input logic [15:0] v);
    @(negedge clk);
    reset = 1'b1;
    set_in(v);
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pin(input string name, input int unsigned t, input logic [3:0] an_e,
                     input logic [6:0] seg_nb_e, input logic [6:0] seg_lz_e);
    wait_edge(t);
    chk({name, "_an"}, 16'(an_nb), 16'(an_e));
    chk({name, "_nb"}, 16'(seg_nb), 16'(seg_nb_e));
    chk({name, "_lz"}, 16'(seg_lz), 16'(seg_lz_e));
  endtask

  initial begin
    // Reset state with arbitrary inputs, then scan order on 0x4321
    set_in(16'hBEEF);
    repeat (3) @(negedge clk);
    chk("rst_an", 16'(an_nb), 16'hF);
    chk("rst_seg", 16'(seg_lz), 16'h00);
    set_in(16'h4321);
    reset = 1'b0;
    pin("first", 1, 4'hE, 7'h3F, 7'h3F);
    pin("scan_d0", 2, 4'hE, 7'h06, 7'h06);
    pin("scan_d1", 5, 4'hD, 7'h5B, 7'h5B);
    pin("scan_d2", 9, 4'hB, 7'h4F, 7'h4F);
    pin("scan_d3", 13, 4'h7, 7'h66, 7'h66);
    pin("scan_wrap", 17, 4'hE, 7'h06, 7'h06);

    // Leading-zero blanking
    restart(16'h0050);
    pin("lz_d0", 2, 4'hE, 7'h3F, 7'h3F);
    pin("lz_d1", 5, 4'hD, 7'h6D, 7'h6D);
    pin("lz_d2", 9, 4'hB, 7'h3F, 7'h00);
    set_in(16'h0000);
    pin("lz_d3", 13, 4'h7, 7'h3F, 7'h00);
    pin("zero_d0", 17, 4'hE, 7'h3F, 7'h3F);
    pin("zero_d1", 21, 4'hD, 7'h3F, 7'h00);
    set_in(16'h0F00);
    pin("f00_d0", 33, 4'hE, 7'h3F, 7'h3F);
    pin("f00_d1", 37, 4'hD, 7'h3F, 7'h3F);
    pin("f00_d2", 41, 4'hB, 7'h71, 7'h71);
    pin("f00_d3", 45, 4'h7, 7'h3F, 7'h00);

    // No tearing: inputs change while digit 1 is shown
    restart(16'h1234);
    wait_edge(6);
    set_in(16'hABCD);
    pin("tear_d2", 9, 4'hB, 7'h5B, 7'h5B);
    pin("tear_d3", 13, 4'h7, 7'h06, 7'h06);
    pin("new_d0", 17, 4'hE, 7'h5E, 7'h5E);
    pin("new_d1", 21, 4'hD, 7'h39, 7'h39);
    pin("new_d2", 25, 4'hB, 7'h7C, 7'h7C);
    pin("new_d3", 29, 4'h7, 7'h77, 7'h77);

    // Asynchronous reset mid-frame while digit 2 is shown
    wait_edge(42);
    #1 reset = 1'b1;
    #1;
    chk("async_an", 16'(an_lz), 16'hF);
    chk("async_seg", 16'(seg_nb), 16'h00);
    set_in(16'h9876);
    @(negedge clk);
    reset = 1'b0;
    pin("rerun_first", 1, 4'hE, 7'h3F, 7'h3F);
    pin("rerun_d0", 2, 4'hE, 7'h7D, 7'h7D);

    // Random inputs for 200 frames, with biased leading zeros and rare resets
    restart(16'(($urandom) & 32'hFFFF));
    for (int c = 0; c < 200 * 4 * SD; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        in0 = 4'($urandom);
        in1 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
        in2 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
        in3 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      end
      if (c == 1000 || c == 2300) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_4digit.md
# display_scan_4digit

Multiplexed four-digit seven-segment display driver that consumes the four 4-bit digit outputs of the 16-bit latch stage and drives a common-anode panel. It divides the system clock into a digit scan rate and captures a coherent snapshot of all four digits once per frame, so a value changing mid-scan never tears. Each digit is decoded to hex glyphs, with optional leading-zero blanking. It sits between the latch and the board pins.

## Interface

- SCAN_DIV, 50000, clock cycles each digit is held active (≥2)
- BLANK_LZ, 1, 1 = blank leading zeros on digits 3..1; 0 = show all digits
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- in0  input  4  digit 0, least significant
- in1  input  4  digit 1
- in2  input  4  digit 2
- in3  input  4  digit 3, most significant
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high lit
- an  output  4  digit enables, active-low; an[k] selects digit k

## Operation

- One clock; reset is asynchronous and active-high.
- Prescaler `div_cnt` counts 0..SCAN_DIV-1 and wraps. `tick` is asserted when div_cnt == SCAN_DIV-1.
- Digit index `idx` (2 bits) increments on tick and wraps 3→0.
- Snapshot register `snap[15:0]` = {in3,in2,in1,in0}. It loads on `frame_load`, and holds at all other times. `frame_load` is asserted in two cases:
  - on the first clock edge after reset deasserts (one-shot flag); and
  - on the tick that wraps idx 3→0.
- Blanking (BLANK_LZ=1):
  - digit 3 is blank iff snap[15:12]==0;
  - digit 2 is blank iff snap[15:8]==0;
  - digit 1 is blank iff snap[15:4]==0;
  - digit 0 is never blank.
  - With BLANK_LZ=0, no digit is blanked.
- Decode is hex, with seg given in hex:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - A blank digit gives seg=00.
- Output registers:
  - an ← ~(4'b0001 << idx)
  - seg ← glyph(snap nibble idx), or 00 if that digit is blank.
  - Both update every clock from the current idx and snap.

## Timing

- Reset values:
  - div_cnt=0, idx=0, snap=0000, load flag set
  - an=1111 (all off), seg=00
- First clock after reset release:
  - an=1110;
  - seg shows glyph(snap=0, digit 0) = 3F;
  - snap captures the inputs on this same edge.
- Second clock: seg reflects the captured in0.
- Output pipeline:
  - an and seg change exactly one clock after idx changes.
  - Each digit is active for SCAN_DIV cycles.
  - One frame lasts 4·SCAN_DIV cycles.
- Input changes become visible only at the next frame_load. Visible latency ≤ 4·SCAN_DIV+1 cycles.
- Input change on the exact edge of frame_load: the value sampled on that edge is used.
- Reset mid-frame: all state returns to reset values immediately, with no waiting for a clock edge. The load sequence then restarts.
- Only one digit is active at a time; an never has two bits low.

## Structure

- Shared package `display_pkg`:
  - glyph constants GLYPH_0..GLYPH_F and SEG_BLANK;
  - default SCAN_DIV;
  - AN_OFF = 4'b1111.
- Sub-module `seg7_hex_decoder` (purely combinational, 4-bit in, 7-bit out). It is instantiated once, on the selected nibble.
- Top level contains the prescaler, idx counter, load flag, snapshot, blank logic and output registers.

## Test plan

All scenarios run with SCAN_DIV=4.

- **Reset state:** reset held with arbitrary inputs → an=1111, seg=00. Release → next edge an=1110, seg=3F.
- **Scan order:** inputs {in3..in0}={4,3,2,1}, BLANK_LZ=0 → an cycles 1110/1101/1011/0111 with seg 06/5B/4F/66, each for 4 clocks; frame period is 16 clocks.
- **Leading-zero blanking:** input 0x0050, BLANK_LZ=1 → digit0 seg=3F, digit1 seg=6D, digits 2 and 3 seg=00. Input 0x0000 → only digit0 lit (3F). Input 0x0F00 with BLANK_LZ=1 → digit3 blank, digit2=71, digits 1 and 0 = 3F.
- **No tearing:** change inputs 0x1234→0xABCD while idx=1 → remaining digits of that frame still show 0x1234 glyphs. The next frame shows 5E/39/7C/77 for digits 0..3.
- **Reset mid-frame:** assert reset while idx=2 → an=1111 and seg=00 asynchronously, before any clock edge. After release, the sequence restarts at digit 0 with a fresh capture.
- **One-hot enables:** random inputs for 200 frames → an is never 1111 after startup and never has more than one zero bit.
